// File: rtl/receptor_morse.sv
// rtl/receptor_morse.sv - Morse receiver: times key marks/spaces, decodes A-Z, 0-9 and word spaces to ASCII
module receptor_morse #(
  parameter int UNIT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [6:0] ascii,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int CNT_MAX = 8 * UNIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MAX_C  = CW'(CNT_MAX);
  localparam logic [CW-1:0] DASH_C = CW'(2 * UNIT_CYCLES);
  localparam logic [CW-1:0] CHAR_C = CW'(2 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WORD_C = CW'(5 * UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, WORD_WAIT} state_t;

  state_t          state_q;
  logic            key_meta_q, key_s_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      sym_q;
  logic [2:0]      n_q;
  logic            ovf_q;
  logic [6:0]      ascii_q;
  logic            valid_q, err_q, busy_q;

  logic [CW-1:0]   cnt_inc_d;
  logic            dash_d;
  logic [4:0]      sym_app_d;
  logic [7:0]      dec_d;

  // Returns {err, ascii}; sym bit i is element i (first element at bit 0), 1 = dash.
  function automatic logic [7:0] decode(input logic [2:0] n, input logic [4:0] s);
    case ({n, s})
      {3'd1, 5'b00000}: decode = {1'b0, 7'h45}; // E
      {3'd1, 5'b00001}: decode = {1'b0, 7'h54}; // T
      {3'd2, 5'b00000}: decode = {1'b0, 7'h49}; // I
      {3'd2, 5'b00010}: decode = {1'b0, 7'h41}; // A
      {3'd2, 5'b00001}: decode = {1'b0, 7'h4E}; // N
      {3'd2, 5'b00011}: decode = {1'b0, 7'h4D}; // M
      {3'd3, 5'b00000}: decode = {1'b0, 7'h53}; // S
      {3'd3, 5'b00100}: decode = {1'b0, 7'h55}; // U
      {3'd3, 5'b00010}: decode = {1'b0, 7'h52}; // R
      {3'd3, 5'b00110}: decode = {1'b0, 7'h57}; // W
      {3'd3, 5'b00001}: decode = {1'b0, 7'h44}; // D
      {3'd3, 5'b00101}: decode = {1'b0, 7'h4B}; // K
      {3'd3, 5'b00011}: decode = {1'b0, 7'h47}; // G
      {3'd3, 5'b00111}: decode = {1'b0, 7'h4F}; // O
      {3'd4, 5'b00000}: decode = {1'b0, 7'h48}; // H
      {3'd4, 5'b01000}: decode = {1'b0, 7'h56}; // V
      {3'd4, 5'b00100}: decode = {1'b0, 7'h46}; // F
      {3'd4, 5'b00010}: decode = {1'b0, 7'h4C}; // L
      {3'd4, 5'b00110}: decode = {1'b0, 7'h50}; // P
      {3'd4, 5'b01110}: decode = {1'b0, 7'h4A}; // J
      {3'd4, 5'b00001}: decode = {1'b0, 7'h42}; // B
      {3'd4, 5'b01001}: decode = {1'b0, 7'h58}; // X
      {3'd4, 5'b00101}: decode = {1'b0, 7'h43}; // C
      {3'd4, 5'b01101}: decode = {1'b0, 7'h59}; // Y
      {3'd4, 5'b00011}: decode = {1'b0, 7'h5A}; // Z
      {3'd4, 5'b01011}: decode = {1'b0, 7'h51}; // Q
      {3'd5, 5'b11110}: decode = {1'b0, 7'h31};
      {3'd5, 5'b11100}: decode = {1'b0, 7'h32};
      {3'd5, 5'b11000}: decode = {1'b0, 7'h33};
      {3'd5, 5'b10000}: decode = {1'b0, 7'h34};
      {3'd5, 5'b00000}: decode = {1'b0, 7'h35};
      {3'd5, 5'b00001}: decode = {1'b0, 7'h36};
      {3'd5, 5'b00011}: decode = {1'b0, 7'h37};
      {3'd5, 5'b00111}: decode = {1'b0, 7'h38};
      {3'd5, 5'b01111}: decode = {1'b0, 7'h39};
      {3'd5, 5'b11111}: decode = {1'b0, 7'h30};
      default:          decode = {1'b1, 7'h00};
    endcase
  endfunction

  assign cnt_inc_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
  assign dash_d    = (cnt_q >= DASH_C);
  assign sym_app_d = sym_q | (5'(dash_d) << n_q);
  assign dec_d     = ovf_q ? {1'b1, 7'h00} : decode(n_q, sym_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
      cnt_q      <= '0;
      sym_q      <= '0;
      n_q        <= '0;
      ovf_q      <= 1'b0;
      ascii_q    <= 7'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      key_meta_q <= key_in;
      key_s_q    <= key_meta_q;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_s_q) begin
            state_q <= MARK;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
          end
        end
        MARK: begin
          if (key_s_q) begin
            cnt_q <= cnt_inc_d;
          end else begin
            if (n_q == 3'd5) begin
              ovf_q <= 1'b1;
            end else begin
              sym_q <= sym_app_d;
              n_q   <= n_q + 3'd1;
            end
            state_q <= SPACE;
            cnt_q   <= CW'(1);
          end
        end
        SPACE: begin
          // A rising key on the threshold cycle wins over the emission.
          if (key_s_q) begin
            state_q <= MARK;
            cnt_q   <= CW'(1);
          end else if (cnt_q == CHAR_C) begin
            valid_q <= 1'b1;
            err_q   <= dec_d[7];
            ascii_q <= dec_d[6:0];
            sym_q   <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
            state_q <= WORD_WAIT;
            cnt_q   <= cnt_inc_d;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        WORD_WAIT: begin
          if (key_s_q) begin
            state_q <= MARK;
            cnt_q   <= CW'(1);
          end else if (cnt_q == WORD_C) begin
            valid_q <= 1'b1;
            ascii_q <= 7'h20;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ascii = ascii_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_receptor_morse.sv
// tb/tb_receptor_morse.sv - directed bench for receptor_morse with an expected-character queue
module tb_receptor_morse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in = 1'b0;
  logic [6:0] ascii;
  logic       valid, err, busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  receptor_morse #(.UNIT_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .ascii  (ascii),
    .valid  (valid),
    .err    (err),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // '.' = 4-cycle mark, '-' = 12-cycle mark, 4-cycle gaps, last gap given.
  task automatic send(input string pat, input int last_gap);
    for (int i = 0; i < pat.len(); i++) begin
      hold(1'b1, (pat[i] == 8'h2D) ? 12 : 4);
      hold(1'b0, (i == pat.len() - 1) ? last_gap : 4);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", {31'd0, valid}, 32'd0);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("char", {24'd0, err, ascii}, {24'd0, e});
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ascii", {25'd0, ascii}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single E with exact latency checks
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h20);
    key_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_early", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    key_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("e_valid_early", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("e_valid", {31'd0, valid}, 32'd1);
    chk("e_ascii", {25'd0, ascii}, 32'h45);
    chk("e_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    chk("e_valid_drop", {31'd0, valid}, 32'd0);
    hold(1'b0, 29);
    chk("busy_idle", {31'd0, busy}, 32'd0);

    exp_q.push_back(8'h41); exp_q.push_back(8'h20);
    send(".-", 40);

    exp_q.push_back(8'h53); exp_q.push_back(8'h4F); exp_q.push_back(8'h53); exp_q.push_back(8'h20);
    send("...", 12);
    send("---", 12);
    send("...", 40);

    exp_q.push_back(8'h30); exp_q.push_back(8'h35); exp_q.push_back(8'h36); exp_q.push_back(8'h20);
    send("-----", 12);
    send(".....", 12);
    send("-....", 40);

    exp_q.push_back(8'h80); exp_q.push_back(8'h80); exp_q.push_back(8'h45); exp_q.push_back(8'h20);
    send("......", 12);
    send("..--", 12);
    send(".", 40);

    // Mark length boundary and stuck-on key
    exp_q.push_back(8'h45); exp_q.push_back(8'h20);
    hold(1'b1, 7); hold(1'b0, 40);
    exp_q.push_back(8'h54); exp_q.push_back(8'h20);
    hold(1'b1, 8); hold(1'b0, 40);
    exp_q.push_back(8'h54); exp_q.push_back(8'h20);
    hold(1'b1, 40); hold(1'b0, 40);

    // Gap boundaries: key returning on the threshold cycle suppresses emission
    exp_q.push_back(8'h49); exp_q.push_back(8'h20);
    hold(1'b1, 4); hold(1'b0, 7); hold(1'b1, 4); hold(1'b0, 40);
    exp_q.push_back(8'h45); exp_q.push_back(8'h45); exp_q.push_back(8'h20);
    hold(1'b1, 4); hold(1'b0, 8); hold(1'b1, 4); hold(1'b0, 40);
    exp_q.push_back(8'h45); exp_q.push_back(8'h45); exp_q.push_back(8'h20);
    hold(1'b1, 4); hold(1'b0, 19); hold(1'b1, 4); hold(1'b0, 40);

    // Reset in the middle of a dash
    hold(1'b1, 6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ascii", {25'd0, ascii}, 32'h00);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    key_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b0, 10);
    exp_q.push_back(8'h45); exp_q.push_back(8'h20);
    hold(1'b1, 4); hold(1'b0, 40);

    hold(1'b0, 10);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
